// File: rtl/multicycle_control.sv
// Control sequencer for a shared multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Latency: j/beq 3, R/sw/addi 4, lw 5 cycles, plus one cycle per mem_ready=0 cycle in FETCH/MEMRD/MEMWR.
// Backpressure: FETCH, MEMRD and MEMWR hold, with their strobes asserted, until mem_ready is seen.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             bad_op
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t st;

  assign state = st;

  // Sequence state, count fetched instructions and latch illegal opcodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= FETCH;
      instr_count <= '0;
      bad_op      <= 1'b0;
    end else begin
      case (st)
        FETCH: begin
          if (mem_ready) begin
            st          <= DECODE;
            instr_count <= instr_count + CNT_ONE;
          end
        end
        DECODE: begin
          case (op)
            OP_RTYPE:      st <= EXEC;
            OP_LW, OP_SW:  st <= MEMADR;
            OP_BEQ:        st <= BRANCH;
            OP_J:          st <= JUMP;
            OP_ADDI:       st <= ADDIEX;
            default: begin
              st     <= FETCH;
              bad_op <= 1'b1;
            end
          endcase
        end
        MEMADR:  st <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   if (mem_ready) st <= MEMWB;
        MEMWB:   st <= FETCH;
        MEMWR:   if (mem_ready) st <= FETCH;
        EXEC:    st <= RWB;
        RWB:     st <= FETCH;
        BRANCH:  st <= FETCH;
        JUMP:    st <= FETCH;
        ADDIEX:  st <= ADDIWB;
        ADDIWB:  st <= FETCH;
        default: st <= FETCH;
      endcase
    end
  end

  // Decode datapath controls from the current state; everything is held low during reset.
  always_comb begin
    pc_en    = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;
    if (!rst) begin
      case (st)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          pc_en   = mem_ready;
        end
        DECODE: ALUSrcB = 2'b11;
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          PCSource = 2'b01;
          pc_en    = zero;
        end
        JUMP: begin
          PCSource = 2'b10;
          pc_en    = 1'b1;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ADDIWB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model plus directed literal scenarios.
// Two instances share stimulus; the second uses a 2-bit counter to exercise wrap-around.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic [15:0] instr_count;
  logic        bad_op;

  logic        pc_en2, IorD2, MemRead2, MemWrite2, IRWrite2, RegDst2, MemToReg2, RegWrite2, ALUSrcA2;
  logic [1:0]  ALUSrcB2, ALUOp2, PCSource2;
  logic [3:0]  state2;
  logic [1:0]  instr_count2;
  logic        bad_op2;

  multicycle_control #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
    .instr_count(instr_count), .bad_op(bad_op)
  );

  multicycle_control #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en2), .IorD(IorD2), .MemRead(MemRead2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .RegDst(RegDst2), .MemToReg(MemToReg2), .RegWrite(RegWrite2), .ALUSrcA(ALUSrcA2),
    .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .PCSource(PCSource2), .state(state2),
    .instr_count(instr_count2), .bad_op(bad_op2)
  );

  always #5 clk = ~clk;

  // Control bundle, MSB first: pc_en IorD MemRead MemWrite IRWrite RegDst MemToReg RegWrite ALUSrcA ALUSrcB ALUOp PCSource
  logic [14:0] ctl_vec;
  assign ctl_vec = {pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                    ALUSrcA, ALUSrcB, ALUOp, PCSource};
  logic [14:0] ctl_vec2;
  assign ctl_vec2 = {pc_en2, IorD2, MemRead2, MemWrite2, IRWrite2, RegDst2, MemToReg2, RegWrite2,
                     ALUSrcA2, ALUSrcB2, ALUOp2, PCSource2};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each instruction is a list of state codes visited in order (4 bits per step, step 0 in the LSBs).
  function automatic logic [19:0] path_codes(input logic [5:0] o);
    case (o)
      6'b000000: return 20'h07610;
      6'b100011: return 20'h43210;
      6'b101011: return 20'h05210;
      6'b000100: return 20'h00810;
      6'b000010: return 20'h00910;
      6'b001000: return 20'h0BA10;
      default:   return 20'h00010;
    endcase
  endfunction

  function automatic int path_len(input logic [5:0] o);
    case (o)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      6'b001000: return 4;
      default:   return 2;
    endcase
  endfunction

  function automatic logic [3:0] code_at(input logic [5:0] o, input int i);
    logic [19:0] p;
    p = path_codes(o);
    return p[i*4 +: 4];
  endfunction

  // Required control bundle for a state code, written field by field from the state table.
  function automatic logic [14:0] ctl_of(input logic [3:0] c, input logic mr, input logic z);
    logic pe, iod, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pe, iod, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
    asb = 2'd0; aop = 2'd0; pcs = 2'd0;
    case (c)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pe = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pe = z; end
      4'd9:  begin pcs = 2'b10; pe = 1; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pe, iod, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs};
  endfunction

  // Reference model: position within the current instruction, fetch count, sticky illegal flag.
  int          m_idx = 0;
  logic [15:0] m_cnt = 16'd0;
  logic        m_bad = 1'b0;
  logic [3:0]  m_code;

  always @(posedge clk) begin
    if (rst) begin
      m_idx = 0;
      m_cnt = 16'd0;
      m_bad = 1'b0;
    end else begin
      m_code = code_at(op, m_idx);
      if (!((m_code == 4'd0 || m_code == 4'd3 || m_code == 4'd5) && !mem_ready)) begin
        if (m_idx == 0) m_cnt = m_cnt + 16'd1;
        m_idx = m_idx + 1;
        if (m_idx == path_len(op)) begin
          if (path_len(op) == 2) m_bad = 1'b1;
          m_idx = 0;
        end
      end
    end
  end

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        bad;
  } obs_t;
  obs_t trace[$];

  logic [3:0]  e_st;
  logic [14:0] e_ctl;
  logic [15:0] e_cnt;
  logic        e_bad;

  // Compare every cycle at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      e_st = 4'd0; e_ctl = 15'd0; e_cnt = 16'd0; e_bad = 1'b0;
    end else begin
      e_st  = code_at(op, m_idx);
      e_ctl = ctl_of(e_st, mem_ready, zero);
      e_cnt = m_cnt;
      e_bad = m_bad;
    end
    check("state", {28'd0, state}, {28'd0, e_st});
    check("controls", {17'd0, ctl_vec}, {17'd0, e_ctl});
    check("instr_count", {16'd0, instr_count}, {16'd0, e_cnt});
    check("bad_op", {31'd0, bad_op}, {31'd0, e_bad});
    check("state_w2", {28'd0, state2}, {28'd0, e_st});
    check("controls_w2", {17'd0, ctl_vec2}, {17'd0, e_ctl});
    check("instr_count_w2", {30'd0, instr_count2}, {30'd0, e_cnt[1:0]});
    check("rw_mw_exclusive", {31'd0, RegWrite & MemWrite}, 32'd0);
    trace.push_back('{st: state, ctl: ctl_vec, cnt: instr_count, cnt2: instr_count2, bad: bad_op});
  end

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [5:0] o, input logic z, input logic [15:0] mr, input int n);
    trace.delete();
    op   = o;
    zero = z;
    for (int i = 0; i < n; i++) begin
      mem_ready = mr[i];
      tick();
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b000010;
      5: return 6'b001000;
      6: return 6'($urandom_range(0, 63));
      default: return 6'b100011;
    endcase
  endfunction

  int s_r[5]   = '{0, 1, 6, 7, 0};
  int s_lw[8]  = '{0, 1, 2, 3, 3, 3, 4, 0};
  int s_bq[4]  = '{0, 1, 8, 0};
  int s_bad[4] = '{0, 1, 0, 0};
  int s_sw[4]  = '{0, 1, 2, 5};
  int c_j[5]   = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // R-type with memory always ready.
    run(6'b000000, 1'b0, 16'b01111, 5);
    for (int i = 0; i < 5; i++) begin
      check("rtype_state", {28'd0, trace[i].st}, s_r[i]);
      check("rtype_regwrite", {31'd0, trace[i].ctl[7]}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("rtype_count", {16'd0, trace[4].cnt}, 32'd1);

    // lw with two wait cycles in MEMRD.
    run(6'b100011, 1'b0, 16'b01100111, 8);
    for (int i = 0; i < 8; i++) check("lw_state", {28'd0, trace[i].st}, s_lw[i]);
    for (int i = 3; i < 6; i++) check("lw_memread_hold", {31'd0, trace[i].ctl[12]}, 32'd1);
    check("lw_wb_regwrite", {31'd0, trace[6].ctl[7]}, 32'd1);
    check("lw_wb_memtoreg", {31'd0, trace[6].ctl[8]}, 32'd1);

    // beq taken then not taken.
    run(6'b000100, 1'b1, 16'b0111, 4);
    for (int i = 0; i < 4; i++) check("beq_state", {28'd0, trace[i].st}, s_bq[i]);
    check("beq_taken_pc_en", {31'd0, trace[2].ctl[14]}, 32'd1);
    check("beq_pcsource", {30'd0, trace[2].ctl[1:0]}, 32'd1);
    run(6'b000100, 1'b0, 16'b0111, 4);
    check("beq_not_taken_pc_en", {31'd0, trace[2].ctl[14]}, 32'd0);

    // Illegal opcode.
    run(6'b111111, 1'b0, 16'b0011, 4);
    for (int i = 0; i < 4; i++) begin
      check("bad_state", {28'd0, trace[i].st}, s_bad[i]);
      check("bad_no_write", {30'd0, trace[i].ctl[7], trace[i].ctl[11]}, 32'd0);
    end
    check("bad_flag_before", {31'd0, trace[1].bad}, 32'd0);
    check("bad_flag_after", {31'd0, trace[3].bad}, 32'd1);

    // Reset pulse while sw waits in MEMWR.
    run(6'b101011, 1'b0, 16'b0111, 4);
    for (int i = 0; i < 4; i++) check("sw_state", {28'd0, trace[i].st}, s_sw[i]);
    check("sw_memwrite", {31'd0, trace[3].ctl[11]}, 32'd1);
    trace.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_state", {28'd0, trace[0].st}, 32'd0);
    check("rst_memwrite", {31'd0, trace[0].ctl[11]}, 32'd0);
    check("rst_count", {16'd0, trace[0].cnt}, 32'd0);
    check("rst_bad", {31'd0, trace[0].bad}, 32'd0);
    check("post_rst_memread", {31'd0, trace[1].ctl[12]}, 32'd1);

    // Five jumps: the 2-bit counter wraps.
    run(6'b000010, 1'b0, 16'hFFFF, 15);
    for (int k = 0; k < 5; k++) begin
      check("j_count_w2", {30'd0, trace[3*k+1].cnt2}, c_j[k]);
      check("j_state", {28'd0, trace[3*k+2].st}, 32'd9);
      check("j_pc_en", {31'd0, trace[3*k+2].ctl[14]}, 32'd1);
      check("j_pcsource", {30'd0, trace[3*k+2].ctl[1:0]}, 32'd2);
    end

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      if (m_idx == 0) op = pick_op();
      zero      = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 3) != 0);
      if (trace.size() > 64) trace.delete();
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
